// File: rtl/image_core_arbiter_pkg.sv
// Shared types and constants for the image-core arbiter and its round-robin picker.
package img_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int DEF_DWIDTH    = 32;
    localparam int DEF_BURST_LEN = 16;

    // Channel-ID width; never narrower than one bit so a single channel still indexes cleanly.
    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/image_core_arbiter_rr_pick.sv
// Combinational round-robin selector: first asserted request at or after last_i+1, wrapping.
module rr_pick
    import img_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  last_i,
    output logic [IDW-1:0]  grant_o,
    output logic            any_o
);

    logic [IDW-1:0] idx;

    always_comb begin
        grant_o = '0;
        idx     = '0;
        any_o   = |req_i;
        // Walk farthest-to-nearest so the nearest candidate after last_i is written last.
        for (int i = NREQ; i >= 1; i--) begin
            idx = IDW'((int'(last_i) + i) % NREQ);
            if (req_i[idx]) begin
                grant_o = idx;
            end
        end
    end

endmodule

// File: rtl/image_core_arbiter.sv
// Round-robin, burst-locked sharing of one pixel core between NREQ channels with output ID tagging.
// Optional per-channel beat statistics are compiled in with IMG_ARB_STATS_EN.
module image_core_arbiter
    import img_pkg::*;
#(
    parameter int DWIDTH       = DEF_DWIDTH,
    parameter int NREQ         = 2,
    parameter int BURST_LEN    = DEF_BURST_LEN,
    parameter int CORE_LATENCY = 1,
    parameter int IDW          = id_width(NREQ)
) (
    input  logic                   i_clk,
    input  logic                   i_arst_n,
    input  logic [NREQ*DWIDTH-1:0] s_axis_data,
    input  logic [NREQ-1:0]        s_axis_valid,
    output logic [NREQ-1:0]        s_axis_ready,
    output logic [DWIDTH-1:0]      c_axis_data,
    output logic                   c_axis_valid,
    input  logic                   c_axis_ready,
    input  logic                   r_axis_valid,
    output logic [IDW-1:0]         m_axis_id,
    output logic                   m_axis_id_valid
`ifdef IMG_ARB_STATS_EN
    ,
    input  logic                   stat_clr,
    output logic [NREQ*32-1:0]     stat_beats
`endif
);

    localparam int CW = $clog2(BURST_LEN);

    arb_state_e     state_q, state_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [IDW-1:0] last_q, last_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [IDW-1:0] tag_q [CORE_LATENCY];

    logic [IDW-1:0]    pick;
    logic              pick_any;
    logic              beat;
    logic [DWIDTH-1:0] ch_data [NREQ];

    for (genvar k = 0; k < NREQ; k++) begin : g_split
        assign ch_data[k] = s_axis_data[k*DWIDTH +: DWIDTH];
    end

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req_i   (s_axis_valid),
        .last_i  (last_q),
        .grant_o (pick),
        .any_o   (pick_any)
    );

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IDW'(NREQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        c_axis_data  = '0;
        c_axis_valid = 1'b0;
        s_axis_ready = '0;
        beat         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick;
                    state_d = BURST;
                end
            end
            BURST: begin
                c_axis_data           = ch_data[grant_q];
                c_axis_valid          = s_axis_valid[grant_q];
                s_axis_ready[grant_q] = c_axis_ready;
                beat                  = c_axis_valid & c_axis_ready;
                // A dropped valid releases the core at once so waiting channels are not starved.
                if (!s_axis_valid[grant_q] || (beat && cnt_q == CW'(BURST_LEN - 1))) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    last_d  = grant_q;
                end else if (beat) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Tag shift register mirrors the core's free-running valid pipeline.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            for (int i = 0; i < CORE_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= (state_q == BURST) ? grant_q : '0;
            for (int i = 1; i < CORE_LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign m_axis_id       = tag_q[CORE_LATENCY-1];
    assign m_axis_id_valid = r_axis_valid;

`ifdef IMG_ARB_STATS_EN
    for (genvar k = 0; k < NREQ; k++) begin : g_stat
        logic [31:0] beats_q;

        always_ff @(posedge i_clk or negedge i_arst_n) begin
            if (!i_arst_n) begin
                beats_q <= '0;
            end else if (stat_clr) begin
                beats_q <= '0;
            end else if (beat && grant_q == IDW'(k)) begin
                beats_q <= beats_q + 32'd1;
            end
        end

        assign stat_beats[k*32 +: 32] = beats_q;
    end
`endif

endmodule

// File: tb/tb_image_core_arbiter.sv
// Directed bench for image_core_arbiter (NREQ=2, BURST_LEN=4, CORE_LATENCY=1).
module tb_image_core_arbiter;

    localparam int DW   = 32;
    localparam int NR   = 2;
    localparam int BL   = 4;
    localparam int IDWT = 1;

    localparam logic [DW-1:0] D0 = 32'hA5A5_0000;
    localparam logic [DW-1:0] D1 = 32'h5A5A_1111;

    logic              i_clk = 1'b0;
    logic              i_arst_n;
    logic [NR*DW-1:0]  s_axis_data;
    logic [NR-1:0]     s_axis_valid;
    logic [NR-1:0]     s_axis_ready;
    logic [DW-1:0]     c_axis_data;
    logic              c_axis_valid;
    logic              c_axis_ready;
    logic              r_axis_valid;
    logic [IDWT-1:0]   m_axis_id;
    logic              m_axis_id_valid;
`ifdef IMG_ARB_STATS_EN
    logic              stat_clr;
    logic [NR*32-1:0]  stat_beats;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 i_clk = ~i_clk;

    image_core_arbiter #(
        .DWIDTH       (DW),
        .NREQ         (NR),
        .BURST_LEN    (BL),
        .CORE_LATENCY (1),
        .IDW          (IDWT)
    ) dut (
        .i_clk           (i_clk),
        .i_arst_n        (i_arst_n),
        .s_axis_data     (s_axis_data),
        .s_axis_valid    (s_axis_valid),
        .s_axis_ready    (s_axis_ready),
        .c_axis_data     (c_axis_data),
        .c_axis_valid    (c_axis_valid),
        .c_axis_ready    (c_axis_ready),
        .r_axis_valid    (r_axis_valid),
        .m_axis_id       (m_axis_id),
        .m_axis_id_valid (m_axis_id_valid)
`ifdef IMG_ARB_STATS_EN
        ,
        .stat_clr        (stat_clr),
        .stat_beats      (stat_beats)
`endif
    );

    // Core model: an accepted beat emerges one cycle later.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) r_axis_valid <= 1'b0;
        else           r_axis_valid <= c_axis_valid & c_axis_ready;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One cycle: drive valids/ready, then check muxing against the expected owner (-1 = idle).
    task automatic cyc(input logic [1:0] v, input logic cr, input int owner,
                       input logic idv, input logic id, input string tag);
        logic [1:0]    exp_rdy;
        logic          exp_cv;
        logic [DW-1:0] exp_cd;
        @(posedge i_clk);
        #1;
        s_axis_valid = v;
        c_axis_ready = cr;
        #3;
        exp_rdy = 2'b00;
        exp_cv  = 1'b0;
        exp_cd  = '0;
        if (owner == 0) begin
            exp_rdy = cr ? 2'b01 : 2'b00;
            exp_cv  = v[0];
            exp_cd  = D0;
        end else if (owner == 1) begin
            exp_rdy = cr ? 2'b10 : 2'b00;
            exp_cv  = v[1];
            exp_cd  = D1;
        end
        check({tag, ".rdy"}, 32'(s_axis_ready), 32'(exp_rdy));
        check({tag, ".cv"},  32'(c_axis_valid), 32'(exp_cv));
        check({tag, ".cd"},  32'(c_axis_data),  32'(exp_cd));
        check({tag, ".idv"}, 32'(m_axis_id_valid), 32'(idv));
        if (idv) check({tag, ".id"}, 32'(m_axis_id), 32'(id));
    endtask

    initial begin
        s_axis_data  = {D1, D0};
        s_axis_valid = '0;
        c_axis_ready = 1'b1;
        i_arst_n     = 1'b0;
`ifdef IMG_ARB_STATS_EN
        stat_clr     = 1'b0;
`endif
        repeat (2) @(posedge i_clk);
        #1;
        check("rst.rdy", 32'(s_axis_ready), 32'd0);
        check("rst.cv",  32'(c_axis_valid), 32'd0);
        check("rst.id",  32'(m_axis_id),    32'd0);
        i_arst_n = 1'b1;

        // ch0 alone: 1-cycle arbitration, 4-beat burst, one bubble, re-grant, early release.
        cyc(2'b01, 1, -1, 0, 0, "s1c0");
        cyc(2'b01, 1,  0, 0, 0, "s1c1");
        cyc(2'b01, 1,  0, 1, 0, "s1c2");
        cyc(2'b01, 1,  0, 1, 0, "s1c3");
        cyc(2'b01, 1,  0, 1, 0, "s1c4");
        cyc(2'b01, 1, -1, 1, 0, "s1c5");
        cyc(2'b01, 1,  0, 0, 0, "s1c6");
        cyc(2'b00, 1,  0, 1, 0, "s1c7");
        cyc(2'b00, 1, -1, 0, 0, "s1c8");

        // ch1 granted, drops after 2 beats; pending ch0 follows and needs a full fresh count,
        // including a 3-cycle core stall.
        cyc(2'b10, 1, -1, 0, 0, "s3c0");
        cyc(2'b11, 1,  1, 0, 0, "s3c1");
        cyc(2'b11, 1,  1, 1, 1, "s3c2");
        cyc(2'b01, 1,  1, 1, 1, "s3c3");
        cyc(2'b01, 1, -1, 0, 0, "s3c4");
        cyc(2'b01, 1,  0, 0, 0, "s3c5");
        cyc(2'b01, 1,  0, 1, 0, "s3c6");
        cyc(2'b01, 0,  0, 1, 0, "s4c7");
        cyc(2'b01, 0,  0, 0, 0, "s4c8");
        cyc(2'b01, 0,  0, 0, 0, "s4c9");
        cyc(2'b01, 1,  0, 0, 0, "s4c10");
        cyc(2'b01, 1,  0, 1, 0, "s4c11");
        cyc(2'b01, 1, -1, 1, 0, "s4c12");
        cyc(2'b00, 1,  0, 0, 0, "s4c13");
        cyc(2'b00, 1, -1, 0, 0, "s4c14");

        // Both valid after ch0 last served: ch1 wins, then asynchronous reset mid-burst.
        cyc(2'b11, 1, -1, 0, 0, "s5c0");
        cyc(2'b11, 1,  1, 0, 0, "s5c1");
        cyc(2'b11, 1,  1, 1, 1, "s5c2");
        #2;
        i_arst_n = 1'b0;
        #1;
        check("arst.rdy", 32'(s_axis_ready), 32'd0);
        check("arst.cv",  32'(c_axis_valid), 32'd0);
        check("arst.id",  32'(m_axis_id),    32'd0);
        s_axis_valid = '0;
        @(posedge i_clk);
        #3;
        i_arst_n = 1'b1;

        // Both continuously valid: grants 0,1,0,1 with one bubble between bursts.
        cyc(2'b11, 1, -1, 0, 0, "s2c0");
        cyc(2'b11, 1,  0, 0, 0, "s2c1");
        cyc(2'b11, 1,  0, 1, 0, "s2c2");
        cyc(2'b11, 1,  0, 1, 0, "s2c3");
        cyc(2'b11, 1,  0, 1, 0, "s2c4");
        cyc(2'b11, 1, -1, 1, 0, "s2c5");
        cyc(2'b11, 1,  1, 0, 0, "s2c6");
        cyc(2'b11, 1,  1, 1, 1, "s2c7");
        cyc(2'b11, 1,  1, 1, 1, "s2c8");
        cyc(2'b11, 1,  1, 1, 1, "s2c9");
        cyc(2'b11, 1, -1, 1, 1, "s2c10");
        cyc(2'b11, 1,  0, 0, 0, "s2c11");
        cyc(2'b11, 1,  0, 1, 0, "s2c12");
        cyc(2'b11, 1,  0, 1, 0, "s2c13");
        cyc(2'b11, 1,  0, 1, 0, "s2c14");
        cyc(2'b11, 1, -1, 1, 0, "s2c15");
        cyc(2'b11, 1,  1, 0, 0, "s2c16");
        cyc(2'b11, 1,  1, 1, 1, "s2c17");
        cyc(2'b11, 1,  1, 1, 1, "s2c18");
        cyc(2'b11, 1,  1, 1, 1, "s2c19");
        cyc(2'b00, 1, -1, 1, 1, "s2c20");
        cyc(2'b00, 1, -1, 0, 0, "s2c21");

`ifdef IMG_ARB_STATS_EN
        check("stat.ch0", stat_beats[31:0],  32'd8);
        check("stat.ch1", stat_beats[63:32], 32'd8);
        @(posedge i_clk);
        #1;
        stat_clr = 1'b1;
        @(posedge i_clk);
        #1;
        stat_clr = 1'b0;
        #3;
        check("stat.clr0", stat_beats[31:0],  32'd0);
        check("stat.clr1", stat_beats[63:32], 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
